// File: rtl/sha3_absorb_ctrl.sv
// sha3_absorb_ctrl: sequences SHA3 absorb, indexing 16-bit stream words into rate blocks,
// appending pad10*1 padding and handshaking each full block with the permutation.
module sha3_absorb_ctrl #(
    parameter int          RATE_WORDS = 68,
    parameter logic [7:0]  PAD_BYTE   = 8'h06,
    localparam int         IW         = $clog2(RATE_WORDS)
) (
    input  logic          ACLK,
    input  logic          ARESET,
    input  logic          S_TVALID,
    output logic          S_TREADY,
    input  logic [15:0]   S_TDATA,
    input  logic          S_TLAST,
    input  logic [1:0]    S_TUSER,
    output logic          M_VALID,
    output logic [15:0]   M_DATA,
    output logic [IW-1:0] M_INDEX,
    output logic          M_BLOCK_LAST,
    output logic          PERM_START,
    input  logic          PERM_DONE,
    output logic          MSG_DONE,
    output logic          BUSY
);
    typedef enum logic [1:0] {ABSORB, PAD, WAIT_PERM} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          pend_pad_q, pend_pad_d;
    logic          msg_end_q, msg_end_d;
    logic          m_valid_q, m_valid_d;
    logic [15:0]   m_data_q, m_data_d;
    logic [IW-1:0] m_index_q, m_index_d;
    logic          m_block_last_q, m_block_last_d;
    logic          perm_start_q, perm_start_d;
    logic          msg_done_q, msg_done_d;
    logic          busy_q, busy_d;
    logic          hs, emit, at_end, padded;
    logic [15:0]   word;

    assign S_TREADY = (state_q == ABSORB) && !ARESET;
    assign hs       = S_TVALID && S_TREADY;
    assign emit     = hs || (state_q == PAD);
    assign at_end   = cnt_q == IW'(RATE_WORDS - 1);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q        <= ABSORB;
            cnt_q          <= '0;
            pend_pad_q     <= 1'b0;
            msg_end_q      <= 1'b0;
            m_valid_q      <= 1'b0;
            m_data_q       <= '0;
            m_index_q      <= '0;
            m_block_last_q <= 1'b0;
            perm_start_q   <= 1'b0;
            msg_done_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pend_pad_q     <= pend_pad_d;
            msg_end_q      <= msg_end_d;
            m_valid_q      <= m_valid_d;
            m_data_q       <= m_data_d;
            m_index_q      <= m_index_d;
            m_block_last_q <= m_block_last_d;
            perm_start_q   <= perm_start_d;
            msg_done_q     <= msg_done_d;
            busy_q         <= busy_d;
        end
    end

    // A full final word still owes the first pad byte, carried in pend_pad to the next PAD word.
    always_comb begin
        state_d    = state_q;
        cnt_d      = emit ? (at_end ? '0 : cnt_q + 1'b1) : cnt_q;
        pend_pad_d = pend_pad_q;
        msg_end_d  = msg_end_q;
        case (state_q)
            ABSORB: begin
                if (hs && S_TLAST && S_TUSER[1])
                    pend_pad_d = 1'b1;
                if (hs && at_end) begin
                    state_d   = WAIT_PERM;
                    msg_end_d = padded;
                end else if (hs && S_TLAST)
                    state_d = PAD;
            end
            PAD: begin
                pend_pad_d = 1'b0;
                if (at_end) begin
                    state_d   = WAIT_PERM;
                    msg_end_d = 1'b1;
                end
            end
            WAIT_PERM: begin
                if (PERM_DONE) begin
                    state_d   = pend_pad_q ? PAD : ABSORB;
                    msg_end_d = pend_pad_q && msg_end_q;
                end
            end
            default: state_d = ABSORB;
        endcase
    end

    always_comb begin
        padded = (state_q == PAD) || (S_TLAST && !S_TUSER[1]);
        word   = (state_q == PAD) ? (pend_pad_q ? {8'h00, PAD_BYTE} : 16'h0000)
               : !S_TLAST || S_TUSER[1] ? S_TDATA
               : S_TUSER[0] ? {PAD_BYTE, S_TDATA[7:0]}
               : {8'h00, PAD_BYTE};
        if (padded && at_end)
            word[15] = 1'b1;
        m_valid_d      = emit;
        m_data_d       = emit ? word : 16'h0000;
        m_index_d      = emit ? cnt_q : '0;
        m_block_last_d = emit && at_end;
        perm_start_d   = emit && at_end;
        msg_done_d     = emit && at_end && padded;
        busy_d         = !(state_d == ABSORB && cnt_d == '0);
    end

    assign M_VALID      = m_valid_q;
    assign M_DATA       = m_data_q;
    assign M_INDEX      = m_index_q;
    assign M_BLOCK_LAST = m_block_last_q;
    assign PERM_START   = perm_start_q;
    assign MSG_DONE     = msg_done_q;
    assign BUSY         = busy_q;
endmodule

// File: tb/tb_sha3_absorb_ctrl.sv
// tb_sha3_absorb_ctrl: directed checks of the absorb controller with RATE_WORDS=4, PAD_BYTE=8'h06.
module tb_sha3_absorb_ctrl;
    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [15:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic [1:0]  s_tuser = '0;
    logic        m_valid;
    logic [15:0] m_data;
    logic [1:0]  m_index;
    logic        m_block_last;
    logic        perm_start;
    logic        perm_done = 1'b0;
    logic        msg_done;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    logic [20:0] q[$];

    always #5 clk = ~clk;

    sha3_absorb_ctrl #(.RATE_WORDS(4), .PAD_BYTE(8'h06)) dut (
        .ACLK(clk), .ARESET(areset), .S_TVALID(s_tvalid), .S_TREADY(s_tready),
        .S_TDATA(s_tdata), .S_TLAST(s_tlast), .S_TUSER(s_tuser), .M_VALID(m_valid),
        .M_DATA(m_data), .M_INDEX(m_index), .M_BLOCK_LAST(m_block_last),
        .PERM_START(perm_start), .PERM_DONE(perm_done), .MSG_DONE(msg_done), .BUSY(busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
        if (m_valid)
            q.push_back({m_data, m_index, m_block_last, perm_start, msg_done});
    endtask

    task automatic send(input logic [15:0] d, input logic l, input logic [1:0] u);
        int n = 0;
        s_tvalid = 1'b1; s_tdata = d; s_tlast = l; s_tuser = u;
        while (!s_tready && n < 50) begin
            cyc();
            n++;
        end
        checks++;
        if (!s_tready) begin
            errors++;
            $display("FAIL send_timeout ready=%b required 1", s_tready);
        end
        cyc();
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic pulse_done();
        perm_done = 1'b1;
        cyc();
        perm_done = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        cyc();
        checks++;
        if ({s_tready, m_valid, m_data, m_index, m_block_last, perm_start, msg_done, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0",
                     {s_tready, m_valid, m_data, m_index, m_block_last, perm_start, msg_done, busy});
        end
        areset = 1'b0;
        #1;
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b required 1", s_tready);
        end
    endtask

    task automatic test_basic();
        logic [15:0] w[4];
        logic [20:0] e;
        w = '{16'h1111, 16'h2222, 16'h0633, 16'h8000};
        q.delete();
        send(16'h1111, 1'b0, 2'd0);
        send(16'h2222, 1'b0, 2'd0);
        send(16'h3333, 1'b1, 2'd1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            e = {w[i], 2'(i), i == 3, i == 3, i == 3};
            checks++;
            if (q.size() <= i || q[i] !== e) begin
                errors++;
                $display("FAIL basic_w%0d got %h required %h", i, q.size() > i ? q[i] : 21'h0, e);
            end
        end
        cyc();
        cyc();
        checks++;
        if (s_tready !== 1'b0 || busy !== 1'b1 || q.size() != 4) begin
            errors++;
            $display("FAIL basic_wait ready=%b busy=%b words=%0d required 0 1 4", s_tready, busy, q.size());
        end
        pulse_done();
        checks++;
        if (s_tready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle ready=%b busy=%b required 1 0", s_tready, busy);
        end
    endtask

    task automatic test_full_block();
        logic [15:0] w[8];
        logic [20:0] e;
        w = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'h0006, 16'h0000, 16'h0000, 16'h8000};
        q.delete();
        send(16'hAAAA, 1'b0, 2'd0);
        send(16'hBBBB, 1'b0, 2'd0);
        send(16'hCCCC, 1'b0, 2'd0);
        send(16'hDDDD, 1'b1, 2'd2);
        pulse_done();
        checks++;
        if (s_tready !== 1'b0) begin
            errors++;
            $display("FAIL full_pad_ready got %b required 0", s_tready);
        end
        repeat (4) cyc();
        for (int i = 0; i < 8; i++) begin
            e = {w[i], 2'(i % 4), i % 4 == 3, i % 4 == 3, i == 7};
            checks++;
            if (q.size() <= i || q[i] !== e) begin
                errors++;
                $display("FAIL full_w%0d got %h required %h", i, q.size() > i ? q[i] : 21'h0, e);
            end
        end
        pulse_done();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL full_busy got %b required 0", busy);
        end
    endtask

    task automatic test_empty();
        logic [15:0] w[4];
        logic [20:0] e;
        w = '{16'h0006, 16'h0000, 16'h0000, 16'h8000};
        q.delete();
        send(16'hFFFF, 1'b1, 2'd0);
        repeat (3) cyc();
        for (int i = 0; i < 4; i++) begin
            e = {w[i], 2'(i), i == 3, i == 3, i == 3};
            checks++;
            if (q.size() <= i || q[i] !== e) begin
                errors++;
                $display("FAIL empty_w%0d got %h required %h", i, q.size() > i ? q[i] : 21'h0, e);
            end
        end
        pulse_done();
    endtask

    task automatic test_last_at_end();
        logic [15:0] w[8];
        logic [20:0] e;
        w = '{16'h0001, 16'h0002, 16'h0003, 16'h86EE, 16'h0004, 16'h0005, 16'h0006, 16'h8006};
        q.delete();
        send(16'h0001, 1'b0, 2'd0);
        send(16'h0002, 1'b0, 2'd0);
        send(16'h0003, 1'b0, 2'd0);
        send(16'h00EE, 1'b1, 2'd1);
        pulse_done();
        send(16'h0004, 1'b0, 2'd0);
        send(16'h0005, 1'b0, 2'd0);
        send(16'h0006, 1'b0, 2'd0);
        send(16'h1234, 1'b1, 2'd0);
        for (int i = 0; i < 8; i++) begin
            e = {w[i], 2'(i % 4), i % 4 == 3, i % 4 == 3, i % 4 == 3};
            checks++;
            if (q.size() <= i || q[i] !== e) begin
                errors++;
                $display("FAIL lastend_w%0d got %h required %h", i, q.size() > i ? q[i] : 21'h0, e);
            end
        end
        pulse_done();
    endtask

    task automatic test_stall();
        logic [15:0] w[8];
        logic [20:0] e;
        w = '{16'h1010, 16'h2020, 16'h3030, 16'h4040, 16'h5555, 16'h0006, 16'h0000, 16'h8000};
        q.delete();
        pulse_done();
        checks++;
        if (busy !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL stall_idle_done busy=%b words=%0d required 0 0", busy, q.size());
        end
        for (int i = 0; i < 4; i++) begin
            send(w[i], 1'b0, 2'd0);
            s_tdata = 16'hBEEF;
            cyc();
        end
        s_tvalid = 1'b1;
        s_tdata = 16'hDEAD;
        repeat (5) cyc();
        checks++;
        if (q.size() != 4 || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold words=%0d ready=%b required 4 0", q.size(), s_tready);
        end
        pulse_done();
        send(16'h5555, 1'b1, 2'd2);
        pulse_done();
        repeat (2) cyc();
        for (int i = 0; i < 8; i++) begin
            e = {w[i], 2'(i % 4), i % 4 == 3, i % 4 == 3, i == 7};
            checks++;
            if (q.size() <= i || q[i] !== e) begin
                errors++;
                $display("FAIL stall_w%0d got %h required %h", i, q.size() > i ? q[i] : 21'h0, e);
            end
        end
        checks++;
        if (q.size() != 8) begin
            errors++;
            $display("FAIL stall_count got %0d required 8", q.size());
        end
        pulse_done();
    endtask

    task automatic test_reset_mid();
        logic [15:0] w[4];
        logic [20:0] e;
        w = '{16'h1234, 16'h0006, 16'h0000, 16'h8000};
        q.delete();
        send(16'h0000, 1'b1, 2'd0);
        cyc();
        areset = 1'b1;
        cyc();
        areset = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_data, m_index, m_block_last, perm_start, msg_done, busy} !== '0 || s_tready !== 1'b1) begin
            errors++;
            $display("FAIL midreset got %h ready=%b required 0 1",
                     {m_valid, m_data, m_index, m_block_last, perm_start, msg_done, busy}, s_tready);
        end
        q.delete();
        send(16'h1234, 1'b1, 2'd2);
        repeat (3) cyc();
        for (int i = 0; i < 4; i++) begin
            e = {w[i], 2'(i), i == 3, i == 3, i == 3};
            checks++;
            if (q.size() <= i || q[i] !== e) begin
                errors++;
                $display("FAIL midreset_w%0d got %h required %h", i, q.size() > i ? q[i] : 21'h0, e);
            end
        end
        pulse_done();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_block();
        test_empty();
        test_last_at_end();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/sha3_absorb_ctrl.md
Name: sha3_absorb_ctrl

Overview:
- Sequences the absorb phase of the SHA3 core.
- Accepts a 16-bit AXI-stream message, indexes each word within the rate block and applies pad10*1 padding, including whole padding words after TLAST.
- Emits one word per cycle to the state-XOR datapath, pulses a permutation start at every block boundary, and stalls input until the permutation reports done.

Parameters:
RATE_WORDS, 68, rate block size in 16-bit words (1088-bit rate = SHA3-256); legal range 2..256.
PAD_BYTE, 8'h06, domain/first padding byte (8'h01 for plain Keccak, 8'h1F for SHAKE).

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  synchronous reset, active-high
S_TVALID  in  1  input word valid
S_TREADY  out  1  controller can accept a word
S_TDATA  in  16  message word; byte0 = [7:0], byte1 = [15:8]
S_TLAST  in  1  final message word
S_TUSER  in  2  valid bytes in TLAST word: 0, 1 or 2 (3 treated as 2); ignored when TLAST=0
M_VALID  out  1  M_DATA/M_INDEX valid this cycle; no backpressure
M_DATA  out  16  word to XOR into state
M_INDEX  out  $clog2(RATE_WORDS)  word position in rate block
M_BLOCK_LAST  out  1  M_DATA is word RATE_WORDS-1
PERM_START  out  1  one-cycle pulse: start permutation
PERM_DONE  in  1  permutation finished (one-cycle pulse)
MSG_DONE  out  1  one-cycle pulse with PERM_START of the message's final block
BUSY  out  1  high when not (ABSORB state with word count 0)

Behaviour:
- Reset: state ABSORB, cnt=0, pend_pad=0, msg_end=0. M_VALID, M_DATA, M_INDEX, M_BLOCK_LAST, PERM_START, MSG_DONE, BUSY=0. S_TREADY=0 during the ARESET cycle.
- Reset mid-operation discards the current block and message; no PERM_START is issued.
- All outputs are registered. M_* appear 1 cycle after the producing event: an input handshake, or a PAD cycle.
- M_INDEX = cnt at the producing event. cnt increments per emitted word and wraps to 0 after RATE_WORDS-1.
- PERM_START (and MSG_DONE if applicable) assert in the same cycle as the M_VALID word with M_BLOCK_LAST=1.
- S_TREADY = (state==ABSORB) && !ARESET.
- State ABSORB, handshake (S_TVALID && S_TREADY):
  - TLAST=0: out = S_TDATA.
  - TLAST=1, TUSER=2: out = S_TDATA. If cnt<R-1, go to PAD. If cnt==R-1, set pend_pad and go to WAIT_PERM; padding follows in the next block.
  - TLAST=1, TUSER=1: out = {PAD_BYTE, S_TDATA[7:0]}; at cnt==R-1 the high byte is PAD_BYTE|8'h80.
  - TLAST=1, TUSER=0: data ignored; out = first-pad word {8'h00, PAD_BYTE}; at cnt==R-1 it is {8'h80, PAD_BYTE}.
  - Any word at cnt==R-1 goes to WAIT_PERM. msg_end=1 if that word carried padding.
- State PAD: S_TREADY=0; one word per cycle.
  - If pend_pad: the first word is {8'h00, PAD_BYTE}; clear pend_pad.
  - Other words are 16'h0000.
  - The word at cnt==R-1 has 8'h80 ORed into its high byte. Emitting it sets msg_end and goes to WAIT_PERM.
- State WAIT_PERM: S_TREADY=0; wait for PERM_DONE.
  - If pend_pad: go to PAD.
  - Else if msg_end: clear msg_end, go to ABSORB with BUSY low.
  - Else go to ABSORB.
  - PERM_DONE in the same cycle as the PERM_START-producing transition is not possible: PERM_DONE is sampled only in WAIT_PERM and ignored in other states.
- Every message produces exactly ceil((bytes+1)/(2*RATE_WORDS)) blocks. Each block has exactly RATE_WORDS M_VALID words with indices 0..R-1 in order.
- Back-to-back messages: the next message's first word is accepted the cycle after returning to ABSORB.
- S_TDATA changes while S_TVALID=1 && S_TREADY=0 are ignored.

Test Plan (RATE_WORDS=4, PAD_BYTE=8'h06):
- Words 1111, 2222, then 3333 with TLAST, TUSER=1; no stalls -> M_DATA 1111@0, 2222@1, 0633@2, 8000@3. PERM_START and MSG_DONE with index 3. S_TREADY low until PERM_DONE, BUSY then low.
- Four full words AAAA..DDDD, the last with TLAST, TUSER=2 -> block 1 = AAAA, BBBB, CCCC, DDDD with PERM_START and no MSG_DONE. After PERM_DONE, S_TREADY stays 0 and block 2 = 0006, 0000, 0000, 8000 with PERM_START and MSG_DONE.
- Empty message (TLAST, TUSER=0 at index 0) -> 0006, 0000, 0000, 8000; single PERM_START with MSG_DONE.
- Last word 00EE with TUSER=1 at index 3 -> M_DATA 86EE, M_BLOCK_LAST=1, MSG_DONE. A TUSER=0 last at index 3 gives 8006.
- S_TVALID toggling 1/0 with PERM_DONE delayed 5 cycles -> output words are contiguous in index with no duplicates. PERM_DONE pulses outside WAIT_PERM have no effect.
- Assert ARESET in PAD after index 1 -> next cycle all outputs 0 and S_TREADY=1. A new 1-word message then yields a fresh index 0..3 block.
